uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

UART receive block for the uart_led_test design: deserialises 8N1 frames (optionally 8E1) from the `Rx` pin into `RxData` and pulses `RxDone` once per good byte. It is the receiving end of the same link the existing UART transmitter drives. It feeds the seven-segment/LED decode logic in `TOP` and replaces ad-hoc Rx sampling there. It uses 16x oversampling, a two-flop input synchroniser, start-bit glitch rejection and 3-sample majority voting.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `DIV`, default CLK_FREQ/(BAUD*16) = 651: clocks per oversample tick. Must be ≥ 2.
- `Clk` input, 1 bit: system clock, single clock domain.
- `Rst` input, 1 bit: reset, **synchronous, active-high**.
- `Rx` input, 1 bit: asynchronous serial line, idle high.
- `RxData` output, 8 bits: last good byte. Held until the next good byte.
- `RxDone` output, 1 bit: one-cycle pulse when `RxData` updates.
- `RxBusy` output, 1 bit: high while a frame is being received (state ≠ IDLE).
- `FrameErr` output, 1 bit: one-cycle pulse when the stop bit samples low.
- `ParityErr` output, 1 bit: present only with `UART_RX_PARITY_EN`. One-cycle pulse on parity mismatch.

## Operation
- **Synchroniser:** `Rx` passes through 2 flops (`rx_s`), reset to 1. All logic uses `rx_s` only.
- **Tick generator:**
  - Divider counts 0..DIV-1 and emits `tick` on DIV-1.
  - Held at 0 in IDLE, so tick phase is aligned to the start edge.
  - Sub-bit counter `os` runs 0..15 and advances on `tick`.
- **Sampling:** at `os` = 7, 8, 9 sample `rx_s`. The bit value is the majority of the 3 samples, decided at `os` = 9.
- **State machine:**
  - IDLE → START on a falling edge of `rx_s` (previous 1, current 0).
  - START: at the majority decision, 1 → IDLE (glitch, no outputs). 0 → DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted into a holding register. After bit 7 → PARITY if enabled, else STOP.
  - PARITY: evaluate even parity over the 8 data bits plus the parity bit. Then → STOP.
  - STOP: at the majority decision:
    - 1 with no parity error → load `RxData`, pulse `RxDone`.
    - 1 with a parity error → pulse `ParityErr` only; `RxData` unchanged.
    - 0 → pulse `FrameErr`; `RxData` unchanged.
    - In all three cases → IDLE.
- **Re-arming:** IDLE needs `rx_s` high then low to re-arm. A line stuck low after a frame error never starts a spurious frame.
- **Reset values:** `RxData`=0, `RxDone`=0, `RxBusy`=0, `FrameErr`=0, `ParityErr`=0, state IDLE, counters 0. Reset mid-frame abandons the frame with no pulses.

## Timing
- Input latency is 2 clocks (synchroniser) plus 1 clock (edge detect).
- Each bit lasts 16×DIV clocks. Sampling falls at the bit centre ±1 tick, tolerating ±~3% baud mismatch.
- `RxDone`, `FrameErr` and `ParityErr` assert 1 clock after the stop-bit `os`=9 tick. They are registered outputs and are mutually exclusive.
- `RxBusy` rises the clock after the start edge is detected and falls together with the done/error pulse.
- Back-to-back frames are supported: the next start edge is accepted from the first clock after return to IDLE. This is about 6.5 ticks before the stop bit ends.
- At 100 MHz / 9600 baud, one frame is ≈ 104.17 µs × 10 bits. `RxDone` fires ≈ 9.6 bit-times after the start edge.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - Frame format is 8E1 and the PARITY state exists.
  - `ParityErr` port is present.
  - A bad parity suppresses the `RxData` update and `RxDone`.
- **Undefined:**
  - Frame format is 8N1 with no PARITY state.
  - The `ParityErr` port is omitted.
  - DATA goes directly to STOP.

## Test plan
- **Reset:** assert `Rst` 5 clocks mid-frame, then send 0xA5 at 9600 baud. Required: all outputs 0 during reset, no pulses from the aborted frame, then `RxData`=0xA5 with one `RxDone` pulse.
- **Good bytes:** send 0x00, 0xFF, 0x3C back-to-back with no idle gap. Required: three `RxDone` pulses, `RxData` sequence 0x00, 0xFF, 0x3C, `FrameErr` never high.
- **Glitch rejection:** drive a 3 µs low pulse on idle `Rx`. Required: `RxBusy` high < 1 bit-time, then low; no `RxDone`/`FrameErr`; `RxData` unchanged.
- **Framing error:** send 0x55 with the stop bit held low, then release high and send 0x12. Required: one `FrameErr` pulse, `RxData` stays at its prior value, then 0x12 with `RxDone`.
- **Baud tolerance:** send 0x96 with the bit period at +2.5% and then −2.5% of nominal. Required: `RxData`=0x96 both times.
- **Parity (`UART_RX_PARITY_EN` only):** send 0x07 with parity bit 1, then 0x07 with parity bit 0. Required: first gives `RxDone` with `RxData`=0x07; second gives `ParityErr`, no `RxDone`.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 16x-oversampled 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined)
module uart_byte_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       RxBusy,
  output logic       FrameErr
`ifdef UART_RX_PARITY_EN
  ,
  output logic       ParityErr
`endif
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
  state_t        r_state;
  logic [1:0]    r_sync;
  logic          r_rx_d;
  logic [DW-1:0] r_div;
  logic [3:0]    r_os;
  logic [2:0]    r_bit;
  logic [1:0]    r_smp;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_done;
  logic          r_busy;
  logic          r_ferr;
`ifdef UART_RX_PARITY_EN
  logic          r_pbad;
  logic          r_perr;
`endif
  logic w_rx_s;
  logic w_fall;
  logic w_tick;
  logic w_decide;
  logic w_maj;
  assign w_rx_s   = r_sync[1];
  assign w_fall   = r_rx_d & ~w_rx_s;
  assign w_tick   = r_div == DW'(DIV - 1);
  assign w_decide = w_tick && r_os == 4'd9;
  assign w_maj    = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);
  assign RxData   = r_data;
  assign RxDone   = r_done;
  assign RxBusy   = r_busy;
  assign FrameErr = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign ParityErr = r_perr;
`endif
  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync <= 2'b11;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], Rx};
      r_rx_d <= r_sync[1];
    end
  end
  // Oversample divider and sub-bit counter, parked at zero in IDLE so phase tracks the start edge
  always_ff @(posedge Clk) begin
    if (Rst || r_state == S_IDLE) begin
      r_div <= '0;
      r_os  <= 4'd0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      r_os  <= w_tick ? r_os + 4'd1 : r_os;
    end
  end
  // Capture the first two of the three centre samples; the third is the live value at os=9
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_smp <= 2'b00;
    end else begin
      r_smp[0] <= (w_tick && r_os == 4'd7) ? w_rx_s : r_smp[0];
      r_smp[1] <= (w_tick && r_os == 4'd8) ? w_rx_s : r_smp[1];
    end
  end
  // Frame FSM: every state acts only on the majority decision, then the next bit's decision is 16 ticks later
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_decide) begin
            r_state <= w_maj ? S_IDLE : S_DATA;
            r_busy  <= ~w_maj;
            r_bit   <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_decide) begin
            r_shift <= {w_maj, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
            r_state <= (r_bit == 3'd7) ? S_PARITY : S_DATA;
`else
            r_state <= (r_bit == 3'd7) ? S_STOP : S_DATA;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_decide) begin
            r_pbad  <= ^{r_shift, w_maj};
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_decide) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!w_maj)
              r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (r_pbad)
              r_perr <= 1'b1;
`endif
            else begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: randomized self-checking bench for uart_byte_rx against a frame-level event model
module tb_uart_byte_rx;
  localparam int DIV = 8;
  localparam int BIT = 16 * DIV;
  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_PERR = 3'b100;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic       par_err;
  int         n_chk = 0;
  int         n_err = 0;
  int         busy_cnt = 0;
  logic [7:0] m_last = 8'h00;
  logic [10:0] exp_q[$];
  uart_byte_rx #(.DIV(DIV)) dut (
    .Clk(clk),
    .Rst(rst),
    .Rx(rx),
    .RxData(rx_data),
    .RxDone(rx_done),
    .RxBusy(rx_busy),
    .FrameErr(frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .ParityErr(par_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign par_err = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Reference model: a good frame yields DONE with its byte; a bad frame yields an error and keeps the last byte
  task automatic expect_frame(input logic [7:0] b, input logic stop, input logic pflip);
    if (!stop) exp_q.push_back({K_FERR, m_last});
`ifdef UART_RX_PARITY_EN
    else if (pflip) exp_q.push_back({K_PERR, m_last});
`endif
    else begin
      m_last = b;
      exp_q.push_back({K_DONE, b});
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per, input logic pflip);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b ^ pflip;
    repeat (per) @(negedge clk);
`endif
    rx = stop;
    repeat (per) @(negedge clk);
  endtask
  task automatic frame(input logic [7:0] b, input logic stop, input int per, input logic pflip);
    expect_frame(b, stop, pflip);
    send_frame(b, stop, per, pflip);
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 4 * BIT && exp_q.size() > 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rx_busy) busy_cnt++;
    if (!rst && (rx_done || frame_err || par_err)) begin
      if (exp_q.size() == 0) chk("unexpected_event", {par_err, frame_err, rx_done}, 0);
      else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("event_kind", {par_err, frame_err, rx_done}, e[10:8]);
        chk("event_data", rx_data, e[7:0]);
        chk("event_busy", rx_busy, 0);
      end
    end
  end
  initial begin
    logic prev_stop;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_outs", {rx_data, rx_done, rx_busy, frame_err, par_err}, 0);
    rst = 1'b0;
    idle(2 * BIT);
    frame(8'h00, 1'b1, BIT, 1'b0);
    frame(8'hFF, 1'b1, BIT, 1'b0);
    frame(8'h3C, 1'b1, BIT, 1'b0);
    idle(BIT);
    drain("good_drain");
    chk("good_last", rx_data, 8'h3C);
    fork
      send_frame(8'hF0, 1'b1, BIT, 1'b0);
      begin
        repeat (5 * BIT + 40) @(negedge clk);
        chk("pre_reset_busy", rx_busy, 1);
        rst = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("midframe_reset_outs", {rx_data, rx_done, rx_busy, frame_err, par_err}, 0);
        end
        rst = 1'b0;
        m_last = 8'h00;
      end
    join
    idle(2 * BIT);
    chk("aborted_busy", rx_busy, 0);
    chk("aborted_data", rx_data, 8'h00);
    frame(8'hA5, 1'b1, BIT, 1'b0);
    idle(BIT);
    drain("reset_drain");
    chk("reset_a5", rx_data, 8'hA5);
    busy_cnt = 0;
    rx = 1'b0;
    repeat (DIV / 2) @(negedge clk);
    idle(3 * BIT);
    chk("glitch_busy_seen", busy_cnt > 0, 1);
    chk("glitch_busy_short", busy_cnt < BIT, 1);
    chk("glitch_busy_low", rx_busy, 0);
    chk("glitch_data", rx_data, 8'hA5);
    frame(8'h55, 1'b0, BIT, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    chk("stuck_low_busy", rx_busy, 0);
    chk("ferr_data_held", rx_data, 8'hA5);
    idle(2 * BIT);
    frame(8'h12, 1'b1, BIT, 1'b0);
    idle(BIT);
    drain("ferr_drain");
    chk("after_ferr", rx_data, 8'h12);
    frame(8'h96, 1'b1, BIT + BIT / 40, 1'b0);
    idle(2 * BIT);
    drain("fast_drain");
    chk("baud_slow_bits", rx_data, 8'h96);
    m_last = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame(8'h96, 1'b1, BIT - BIT / 40, 1'b0);
    idle(2 * BIT);
    drain("slow_drain");
    chk("baud_fast_bits", rx_data, 8'h96);
`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, BIT, 1'b0);
    idle(BIT);
    drain("par_good_drain");
    chk("par_good", rx_data, 8'h07);
    frame(8'h07, 1'b1, BIT, 1'b1);
    idle(BIT);
    drain("par_bad_drain");
    chk("par_bad_held", rx_data, 8'h07);
`endif
    prev_stop = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       stop;
      logic       pflip;
      int         gap;
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 9) != 0);
      pflip = ($urandom_range(0, 7) == 0);
      gap   = $urandom_range(0, 2) * (BIT / 2);
      if (!prev_stop && gap < BIT) gap = BIT;
      if (gap > 0) idle(gap);
      frame(b, stop, $urandom_range(BIT - 2, BIT + 2), pflip);
      prev_stop = stop;
    end
    idle(2 * BIT);
    drain("random_drain");
    chk("random_last", rx_data, m_last);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
